// File: rtl/page_q_pkg.sv
// page_q_pkg: shared helpers for the page input queue.
//   clog2 : ceiling log2 for sizing pointers
//   tok_w : token width, data bits plus the end-of-stream bit
//   occ_w : occupancy counter width, wide enough to hold DEPTH itself
package page_q_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned tok_w(input int unsigned data_w);
      return data_w + 1;
   endfunction

   function automatic int unsigned occ_w(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/page_q_fifo_ch.sv
// page_q_fifo_ch: one channel of the page input queue, a DEPTH x (DATA_W+1) register FIFO.
// Ports:
//   i_clock         rising-edge clock
//   i_rst_n         synchronous active-low reset
//   i_flush         synchronous clear (same effect as reset)
//   i_d/i_e/i_v     producer token (data, end-of-stream) and valid
//   o_b             producer back-pressure, high when full
//   o_d/o_e/o_v     head token and valid; data/e forced to 0 while empty
//   i_b             consumer back-pressure
//   o_occ           occupancy count
//   o_af            almost-full flag (occ >= AF_LEVEL)
// All outputs come from registers only; no input reaches an output combinationally.
module page_q_fifo_ch
   import page_q_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = 3
) (
   input  logic                      i_clock,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   input  logic [DATA_W-1:0]         i_d,
   input  logic                      i_e,
   input  logic                      i_v,
   output logic                      o_b,
   output logic [DATA_W-1:0]         o_d,
   output logic                      o_e,
   output logic                      o_v,
   input  logic                      i_b,
   output logic [occ_w(DEPTH)-1:0]   o_occ,
   output logic                      o_af
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned OCC_W = occ_w(DEPTH);
   localparam int unsigned TOK_W = tok_w(DATA_W);

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(AF_LEVEL);

   logic [TOK_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [OCC_W-1:0] r_occ;

   logic             w_full;
   logic             w_nempty;
   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] w_occ_nxt;
   logic [TOK_W-1:0] w_head;

   assign w_full   = (r_occ == OCC_FULL);
   assign w_nempty = (r_occ != '0);
   // Push is gated only by our own full flag, so a pop in the same cycle does not
   // open a slot early; this keeps qin_b purely register-derived.
   assign w_push   = i_v & ~w_full;
   assign w_pop    = w_nempty & ~i_b;

   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
         2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_rst_n || i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_occ <= w_occ_nxt;
      end
   end

   // Storage is not reset; stale entries are never visible because occ gates the head.
   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wptr] <= {i_e, i_d};
   end

   assign w_head = r_mem[r_rptr];

   assign o_b   = w_full;
   assign o_v   = w_nempty;
   assign o_d   = w_nempty ? w_head[DATA_W-1:0] : '0;
   assign o_e   = w_nempty & w_head[DATA_W];
   assign o_occ = r_occ;
   assign o_af  = (r_occ >= OCC_AF);

endmodule

// File: rtl/page_qin_multi.sv
// page_qin_multi: NUM_CH independent tokenised stream queues between the page-input
// network and the page operator core.
// Ports:
//   clock, reset (sync, active-low), flush (sync clear of all channels)
//   qin_d/qin_e/qin_v  per-channel input token and valid; channel c at [c*DATA_W +: DATA_W]
//   qin_b              per-channel input back-pressure (1 = full)
//   qout_d/qout_e/qout_v per-channel head token and valid
//   qout_b             per-channel consumer back-pressure
//   occ                per-channel occupancy, occ_w(DEPTH) bits each
//   af                 per-channel almost-full flag
module page_qin_multi
   import page_q_pkg::*;
#(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = 3
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             flush,
   input  logic [NUM_CH*DATA_W-1:0]         qin_d,
   input  logic [NUM_CH-1:0]                qin_e,
   input  logic [NUM_CH-1:0]                qin_v,
   output logic [NUM_CH-1:0]                qin_b,
   output logic [NUM_CH*DATA_W-1:0]         qout_d,
   output logic [NUM_CH-1:0]                qout_e,
   output logic [NUM_CH-1:0]                qout_v,
   input  logic [NUM_CH-1:0]                qout_b,
   output logic [NUM_CH*occ_w(DEPTH)-1:0]   occ,
   output logic [NUM_CH-1:0]                af
);

   localparam int unsigned OCC_W = occ_w(DEPTH);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      page_q_fifo_ch #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .AF_LEVEL (AF_LEVEL)
      ) u_fifo (
         .i_clock (clock),
         .i_rst_n (reset),
         .i_flush (flush),
         .i_d     (qin_d[c*DATA_W +: DATA_W]),
         .i_e     (qin_e[c]),
         .i_v     (qin_v[c]),
         .o_b     (qin_b[c]),
         .o_d     (qout_d[c*DATA_W +: DATA_W]),
         .o_e     (qout_e[c]),
         .o_v     (qout_v[c]),
         .i_b     (qout_b[c]),
         .o_occ   (occ[c*OCC_W +: OCC_W]),
         .o_af    (af[c])
      );
   end

endmodule
